// File: rtl/cursor_tracker.sv
// ---------------------------------------------------------------------------
// cursor_tracker
//
// Accumulates relative mouse movement packets into an absolute (x, y) cursor
// position confined to [0, X_MAX] x [0, Y_MAX], and tracks button levels and
// press events.
//
// Each accepted packet (m_done_tick=1) adds its x/y deltas, scaled by
// 2^GAIN_SHIFT, to the current position. Results outside the window are
// clamped to the nearest bound (WRAP_MODE=0) or wrapped around modulo
// MAX+1 (WRAP_MODE=1). With Y_INVERT=1 a positive y delta moves the cursor
// towards y=0, matching a screen whose y axis grows downward.
//
// A recenter request reloads X_INIT/Y_INIT and takes priority over a packet
// in the same cycle; the packet's buttons are still taken. A packet may
// arrive on every cycle; there is no backpressure.
//
// Ports
//   clk          clock; all state changes on its rising edge
//   rst          synchronous active-high reset
//   m_done_tick  one-cycle strobe: xm/ym/btnm are valid this cycle
//   xm, ym       9-bit two's-complement movement deltas
//   btnm         button levels {middle, right, left}
//   recenter     one-cycle request to reload X_INIT/Y_INIT
//   x_pos, y_pos current cursor position
//   moved        one-cycle pulse: x_pos or y_pos changed at this edge
//   btn_held     registered button levels
//   btn_press    one-cycle rising-edge pulse per button
//   at_edge      {y at Y_MAX, y at 0, x at X_MAX, x at 0}
// ---------------------------------------------------------------------------
module cursor_tracker #(
   parameter int POS_W      = 14,
   parameter int X_MAX      = 6400,
   parameter int Y_MAX      = 4800,
   parameter int X_INIT     = 3200,
   parameter int Y_INIT     = 2400,
   parameter int GAIN_SHIFT = 1,
   parameter int WRAP_MODE  = 0,
   parameter int Y_INVERT   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             m_done_tick,
   input  logic [8:0]       xm,
   input  logic [8:0]       ym,
   input  logic [2:0]       btnm,
   input  logic             recenter,
   output logic [POS_W-1:0] x_pos,
   output logic [POS_W-1:0] y_pos,
   output logic             moved,
   output logic [2:0]       btn_held,
   output logic [2:0]       btn_press,
   output logic [3:0]       at_edge
);

   // Arithmetic width: POS_W magnitude bits, GAIN_SHIFT bits of headroom for
   // the scaled delta, one bit of carry and one sign bit. Neither the sum of
   // a position and a delta nor the wrap correction can overflow it.
   localparam int AW = POS_W + GAIN_SHIFT + 2;

   localparam logic [POS_W-1:0] X_MAX_P  = POS_W'(X_MAX);
   localparam logic [POS_W-1:0] Y_MAX_P  = POS_W'(Y_MAX);
   localparam logic [POS_W-1:0] X_INIT_P = POS_W'(X_INIT);
   localparam logic [POS_W-1:0] Y_INIT_P = POS_W'(Y_INIT);

   localparam logic signed [AW-1:0] X_LIM  = AW'(X_MAX);
   localparam logic signed [AW-1:0] Y_LIM  = AW'(Y_MAX);
   localparam logic signed [AW-1:0] X_SPAN = AW'(X_MAX + 1);
   localparam logic signed [AW-1:0] Y_SPAN = AW'(Y_MAX + 1);

   // Exact sign extension of a 9-bit delta followed by the gain shift.
   function automatic logic signed [AW-1:0] scale_delta(input logic [8:0] raw);
      logic signed [AW-1:0] ext;
      ext = {{(AW-9){raw[8]}}, raw};
      return ext <<< GAIN_SHIFT;
   endfunction

   // Bring an out-of-window sum back into [0, lim]. A single wrap correction
   // is enough because a scaled delta never exceeds the span in magnitude.
   function automatic logic [POS_W-1:0] fold(input logic signed [AW-1:0] sum,
                                             input logic signed [AW-1:0] lim,
                                             input logic signed [AW-1:0] span);
      logic signed [AW-1:0] res;
      if (sum[AW-1]) begin
         res = (WRAP_MODE != 0) ? sum + span : '0;
      end else if (sum > lim) begin
         res = (WRAP_MODE != 0) ? sum - span : lim;
      end else begin
         res = sum;
      end
      return res[POS_W-1:0];
   endfunction

   logic signed [AW-1:0] x_ext;
   logic signed [AW-1:0] y_ext;
   logic signed [AW-1:0] dx;
   logic signed [AW-1:0] dy;
   logic [POS_W-1:0]     x_next;
   logic [POS_W-1:0]     y_next;

   // NOTE: every signal driven here gets a value on every path (the
   // assignments are unconditional), so no latch can be inferred.
   always_comb begin
      x_ext  = {{(AW-POS_W){1'b0}}, x_pos};
      y_ext  = {{(AW-POS_W){1'b0}}, y_pos};
      dx     = scale_delta(xm);
      dy     = (Y_INVERT != 0) ? -scale_delta(ym) : scale_delta(ym);
      x_next = fold(x_ext + dx, X_LIM, X_SPAN);
      y_next = fold(y_ext + dy, Y_LIM, Y_SPAN);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; the reset branch is checked first so it
   // overrides recenter and packets in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_pos     <= X_INIT_P;
         y_pos     <= Y_INIT_P;
         moved     <= 1'b0;
         btn_held  <= 3'b000;
         btn_press <= 3'b000;
      end else begin
         moved     <= 1'b0;
         btn_press <= 3'b000;

         // Position: recenter beats a packet; moved only on an actual change,
         // so a zero delta or a clamp against a reached bound stays silent.
         if (recenter) begin
            x_pos <= X_INIT_P;
            y_pos <= Y_INIT_P;
            moved <= (x_pos != X_INIT_P) || (y_pos != Y_INIT_P);
         end else if (m_done_tick) begin
            x_pos <= x_next;
            y_pos <= y_next;
            moved <= (x_pos != x_next) || (y_pos != y_next);
         end

         // Buttons follow every packet, even one whose motion was discarded.
         if (m_done_tick) begin
            btn_held  <= btnm;
            btn_press <= btnm & ~btn_held;
         end
      end
   end

   assign at_edge = {y_pos == Y_MAX_P, y_pos == '0, x_pos == X_MAX_P, x_pos == '0};

endmodule

// File: doc/cursor_tracker.md
CURSOR_TRACKER -- requirements
Module: cursor_tracker

Interface
REQ-001 Parameters (name, default, meaning):
- POS_W, 14, position register width; SHALL satisfy 2^POS_W > max(X_MAX, Y_MAX).
- X_MAX, 6400, inclusive upper bound of x_pos.
- Y_MAX, 4800, inclusive upper bound of y_pos.
- X_INIT, 3200, x_pos value after reset or recenter.
- Y_INIT, 2400, y_pos value after reset or recenter.
- GAIN_SHIFT, 1, left-shift applied to each raw delta (0..4).
- WRAP_MODE, 0, 0 = clamp at bounds; 1 = wrap modulo (MAX+1).
- Y_INVERT, 1, 1 = positive ym decreases y_pos (screen-down axis).

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on its rising edge.
- rst, in, 1, synchronous active-high reset.
- m_done_tick, in, 1, one-cycle strobe: xm/ym/btnm are valid this cycle.
- xm, in, 9, x delta, two's complement (-256..+255).
- ym, in, 9, y delta, two's complement.
- btnm, in, 3, button levels {middle, right, left}.
- recenter, in, 1, one-cycle request to reload X_INIT/Y_INIT.
- x_pos, out, POS_W, current x position.
- y_pos, out, POS_W, current y position.
- moved, out, 1, one-cycle pulse: x_pos or y_pos changed at this edge.
- btn_held, out, 3, registered button levels.
- btn_press, out, 3, one-cycle rising-edge pulse per button.
- at_edge, out, 4, {y at Y_MAX, y at 0, x at X_MAX, x at 0}, combinational from registers.

Function
REQ-003 The delta for each axis SHALL be the exact sign-extended two's-complement value shifted left by GAIN_SHIFT, with no one's-complement approximation.
REQ-004 When Y_INVERT=1, the y delta SHALL be negated before accumulation.
REQ-005 Arithmetic SHALL be done at signed width POS_W+GAIN_SHIFT+2 so that no intermediate result overflows.
REQ-006 Clamp mode: a sum greater than MAX SHALL load MAX, and a sum less than 0 SHALL load 0.
REQ-007 Wrap mode: a sum greater than MAX SHALL load sum-(MAX+1), and a sum less than 0 SHALL load sum+(MAX+1). One correction suffices because |delta| is at most MAX+1, and the parameters SHALL guarantee this.
REQ-008 Latency:
- Inputs sampled with m_done_tick=1 SHALL produce updated x_pos, y_pos and btn_held at the next rising clk edge.
- moved and btn_press SHALL be asserted in the same cycle as that update, for exactly one cycle.
REQ-009 While m_done_tick=0, positions and btn_held SHALL hold, and moved and btn_press SHALL be 0.
REQ-010 moved SHALL be 1 only if at least one position value actually differs from its previous value. A zero delta, or a clamp at a bound already reached, SHALL leave moved=0.
REQ-011 btn_press[i] SHALL be 1 when btnm[i]=1 and btn_held[i]=0 on a tick.
REQ-012 recenter=1 SHALL load X_INIT/Y_INIT at the next edge and assert moved if either value changes.
REQ-013 recenter and m_done_tick in the same cycle: recenter SHALL win and the deltas SHALL be discarded. Buttons SHALL still update from btnm.
REQ-014 The block SHALL accept a tick on every cycle (back-to-back ticks) without loss; there SHALL be no ready or backpressure signal.

Reset
REQ-015 rst=1 at a clk edge SHALL set:
- x_pos=X_INIT and y_pos=Y_INIT;
- btn_held=0, btn_press=0 and moved=0.
REQ-016 rst SHALL override recenter and m_done_tick in the same cycle, including mid-stream reset.

Verification
REQ-017 Defaults, assert rst for 2 cycles -> x_pos=3200, y_pos=2400, moved=0, btn_held=000, at_edge=0000.
REQ-018 Tick with xm=+10, ym=0 -> next cycle x_pos=3220, y_pos=2400, moved=1; following cycle moved=0.
REQ-019 Tick with ym=+5 (Y_INVERT=1) -> y_pos 2400->2390. Then from x_pos=300, tick with xm=9'h100 (-256, delta -512) -> x_pos=0, at_edge[0]=1. A repeat of the same tick -> moved=0.
REQ-020 WRAP_MODE=1, x_pos=6390, tick with xm=+10 (delta +20) -> x_pos=9. From x_pos=5, tick with xm=-5 (delta -10) -> x_pos=6396.
REQ-021 Tick btnm=001, then tick btnm=001, then tick btnm=000 -> btn_press=001 on the first update only; btn_held=001, then 001, then 000.
REQ-022 From x_pos=4000, recenter=1 together with a tick xm=+50, btnm=010 -> x_pos=3200, btn_press=010, moved=1. rst asserted during a stream of back-to-back ticks -> reset values on the next edge.
